// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 program-memory arbiter.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    IO     = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  // Wide enough for WAIT_CYCLES-1 over the legal range 1..7.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/slc3_mem_arbiter_if.sv
// Requester and SRAM-side bus bundle; slave is the arbiter view, master the environment view.
interface slc3_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ready;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ready,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ready,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/slc3_mmio_regs.sv
// Memory-mapped switch/LED port: address decode, switch read mux and LED register.
module slc3_mmio_regs
  import slc3_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [9:0]        wdata_i,
  input  logic [9:0]        sw_i,
  output logic              io_hit_c_o,
  output logic [DATA_W-1:0] sw_rdata_c_o,
  output logic [9:0]        led_o
);

  logic [9:0] led_q;

  assign io_hit_c_o   = (addr_i == IO_ADDR);
  assign sw_rdata_c_o = DATA_W'({6'b0, sw_i});
  assign led_o        = led_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q <= 10'd0;
    end else if (wr_en_i) begin
      led_q <= wdata_i;
    end
  end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Round-robin arbiter sharing the program SRAM between CPU and loader, with switch/LED MMIO.
// Define SLC3_ARB_STATS_EN to add saturating per-requester grant counters.
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEFAULT)
) (
  input  logic        Clk,
  input  logic        Reset,
  slc3_mem_arbiter_if.slave bus,
  input  logic [9:0]  SW,
  output logic [9:0]  LED,
  output logic        owner
`ifdef SLC3_ARB_STATS_EN
  ,
  output logic [15:0] cpu_grants,
  output logic [15:0] ldr_grants
`endif
);

  arb_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  owner_t            owner_q;
  owner_t            prio_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              cpu_ready_q;
  logic              ldr_ready_q;
  logic              mem_ce_q;
  logic              mem_we_q;

  logic              grant_c;
  owner_t            gnt_owner_c;
  logic              gnt_we_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic [DATA_W-1:0] gnt_wdata_c;
  logic              io_hit_c;
  logic [DATA_W-1:0] sw_rdata_c;
  logic              led_wr_c;

  // Inline round-robin: on contention the favoured side (prio_q) wins.
  always_comb begin
    grant_c     = 1'b0;
    gnt_owner_c = OWN_CPU;
    if (bus.cpu_req && bus.ldr_req) begin
      grant_c     = 1'b1;
      gnt_owner_c = prio_q;
    end else if (bus.cpu_req) begin
      grant_c     = 1'b1;
      gnt_owner_c = OWN_CPU;
    end else if (bus.ldr_req) begin
      grant_c     = 1'b1;
      gnt_owner_c = OWN_LDR;
    end
    gnt_we_c    = (gnt_owner_c == OWN_LDR) ? bus.ldr_we    : bus.cpu_we;
    gnt_addr_c  = (gnt_owner_c == OWN_LDR) ? bus.ldr_addr  : bus.cpu_addr;
    gnt_wdata_c = (gnt_owner_c == OWN_LDR) ? bus.ldr_wdata : bus.cpu_wdata;
  end

  // LED is only written on the IO->DONE edge, so a reset there suppresses it.
  assign led_wr_c = (state_q == IO) && we_q;

  slc3_mmio_regs #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IO_ADDR (IO_ADDR)
  ) u_mmio (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .addr_i       (gnt_addr_c),
    .wr_en_i      (led_wr_c),
    .wdata_i      (wdata_q[9:0]),
    .sw_i         (SW),
    .io_hit_c_o   (io_hit_c),
    .sw_rdata_c_o (sw_rdata_c),
    .led_o        (LED)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_LDR;
      prio_q      <= OWN_LDR;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      ldr_ready_q <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      ldr_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            owner_q <= gnt_owner_c;
            prio_q  <= (gnt_owner_c == OWN_CPU) ? OWN_LDR : OWN_CPU;
            we_q    <= gnt_we_c;
            addr_q  <= gnt_addr_c;
            wdata_q <= gnt_wdata_c;
            if (io_hit_c) begin
              state_q <= IO;
            end else begin
              state_q  <= ACCESS;
              cnt_q    <= CNT_W'(WAIT_CYCLES - 1);
              mem_ce_q <= 1'b1;
              mem_we_q <= gnt_we_c;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!we_q) begin
              if (owner_q == OWN_LDR) ldr_rdata_q <= bus.mem_rdata;
              else                    cpu_rdata_q <= bus.mem_rdata;
            end
            if (owner_q == OWN_LDR) ldr_ready_q <= 1'b1;
            else                    cpu_ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        IO: begin
          if (!we_q) begin
            if (owner_q == OWN_LDR) ldr_rdata_q <= sw_rdata_c;
            else                    cpu_rdata_q <= sw_rdata_c;
          end
          if (owner_q == OWN_LDR) ldr_ready_q <= 1'b1;
          else                    cpu_ready_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.ldr_ready = ldr_ready_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign owner         = (owner_q == OWN_LDR);

`ifdef SLC3_ARB_STATS_EN
  logic [15:0] cpu_grants_q;
  logic [15:0] ldr_grants_q;
  logic        grant_edge_c;

  assign grant_edge_c = (state_q == IDLE) && grant_c;

  // Saturating grant counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_grants_q <= 16'd0;
      ldr_grants_q <= 16'd0;
    end else if (grant_edge_c) begin
      if (gnt_owner_c == OWN_CPU && cpu_grants_q != 16'hFFFF) cpu_grants_q <= cpu_grants_q + 16'd1;
      if (gnt_owner_c == OWN_LDR && ldr_grants_q != 16'hFFFF) ldr_grants_q <= ldr_grants_q + 16'd1;
    end
  end

  assign cpu_grants = cpu_grants_q;
  assign ldr_grants = ldr_grants_q;
`endif

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed bench for slc3_mem_arbiter: vector table plus hand sequences for arbitration,
// request drop, reset abort and a WAIT_CYCLES=1 back-to-back instance.
module tb_slc3_mem_arbiter;
  import slc3_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [9:0] sw;
  logic [9:0] led0, led1;
  logic       owner0, owner1;
  int         n_checks = 0;
  int         n_fail   = 0;

  slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0();
  slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1();

  logic [15:0] sram0 [0:65535];
  logic [15:0] sram1 [0:65535];

  assign bus0.mem_rdata = bus0.mem_ce ? sram0[bus0.mem_addr] : 16'h0000;
  assign bus1.mem_rdata = bus1.mem_ce ? sram1[bus1.mem_addr] : 16'h0000;

  // SRAM models, preloaded while their DUT is in reset.
  always @(posedge clk) begin
    if (rst0) sram0[16'h3000] <= 16'h1234;
    else if (bus0.mem_ce && bus0.mem_we) sram0[bus0.mem_addr] <= bus0.mem_wdata;
  end

  always @(posedge clk) begin
    if (rst1) begin
      for (int k = 0; k < 5; k++) sram1[16'h0010 + k] <= 16'hA000 + 16'(k);
    end else if (bus1.mem_ce && bus1.mem_we) begin
      sram1[bus1.mem_addr] <= bus1.mem_wdata;
    end
  end

`ifdef SLC3_ARB_STATS_EN
  logic [15:0] cpu_grants0, ldr_grants0, cpu_grants1, ldr_grants1;
`endif

  slc3_mem_arbiter u_dut0 (
    .Clk   (clk),
    .Reset (rst0),
    .bus   (bus0),
    .SW    (sw),
    .LED   (led0),
    .owner (owner0)
`ifdef SLC3_ARB_STATS_EN
    ,
    .cpu_grants (cpu_grants0),
    .ldr_grants (ldr_grants0)
`endif
  );

  slc3_mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .Clk   (clk),
    .Reset (rst1),
    .bus   (bus1),
    .SW    (sw),
    .LED   (led1),
    .owner (owner1)
`ifdef SLC3_ARB_STATS_EN
    ,
    .cpu_grants (cpu_grants1),
    .ldr_grants (ldr_grants1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_ldr;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] cpu_rd;
    logic [15:0] ldr_rd;
    bit          ce_seen;
    bit          we_seen;
    logic [9:0]  led;
  } vec_t;

  vec_t vecs [9];

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    sw   = 10'h05A;
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0; bus0.cpu_wdata = 16'h0;
    bus0.ldr_req = 1'b0; bus0.ldr_we = 1'b0; bus0.ldr_addr = 16'h0; bus0.ldr_wdata = 16'h0;
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0; bus1.cpu_wdata = 16'h0;
    bus1.ldr_req = 1'b0; bus1.ldr_we = 1'b0; bus1.ldr_addr = 16'h0; bus1.ldr_wdata = 16'h0;

    //          ldr we  addr      wdata     lat cpu_rd    ldr_rd    ce we led
    vecs[0] = '{0, 0, 16'h3000, 16'h0000, 3, 16'h1234, 16'h0000, 1, 0, 10'h000};
    vecs[1] = '{1, 1, 16'h0031, 16'hBEEF, 3, 16'h1234, 16'h0000, 1, 1, 10'h000};
    vecs[2] = '{0, 0, 16'h0031, 16'h0000, 3, 16'hBEEF, 16'h0000, 1, 0, 10'h000};
    vecs[3] = '{0, 0, 16'hFFFF, 16'h0000, 2, 16'h005A, 16'h0000, 0, 0, 10'h000};
    vecs[4] = '{0, 1, 16'hFFFF, 16'h03C7, 2, 16'h005A, 16'h0000, 0, 0, 10'h3C7};
    vecs[5] = '{1, 0, 16'hFFFF, 16'h0000, 2, 16'h005A, 16'h005A, 0, 0, 10'h3C7};
    vecs[6] = '{1, 1, 16'h4000, 16'h5555, 3, 16'h005A, 16'h005A, 1, 1, 10'h3C7};
    vecs[7] = '{1, 0, 16'h4000, 16'h0000, 3, 16'h005A, 16'h5555, 1, 0, 10'h3C7};
    vecs[8] = '{0, 0, 16'h3000, 16'h0000, 3, 16'h1234, 16'h5555, 1, 0, 10'h3C7};

    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Reset state.
    check("rst cpu_ready", 32'(bus0.cpu_ready), 32'd0);
    check("rst ldr_ready", 32'(bus0.ldr_ready), 32'd0);
    check("rst mem_ce",    32'(bus0.mem_ce),    32'd0);
    check("rst mem_we",    32'(bus0.mem_we),    32'd0);
    check("rst LED",       32'(led0),           32'd0);
    check("rst owner",     32'(owner0),         32'd1);
    check("rst cpu_rdata", 32'(bus0.cpu_rdata), 32'd0);
    check("rst ldr_rdata", 32'(bus0.ldr_rdata), 32'd0);

    // Single-requester transactions from the table.
    for (int i = 0; i < 9; i++) begin
      int lat;
      bit ce_seen, we_seen, oth;
      lat = 0; ce_seen = 1'b0; we_seen = 1'b0; oth = 1'b0;
      @(negedge clk);
      if (vecs[i].is_ldr) begin
        bus0.ldr_req = 1'b1; bus0.ldr_we = vecs[i].we;
        bus0.ldr_addr = vecs[i].addr; bus0.ldr_wdata = vecs[i].wdata;
      end else begin
        bus0.cpu_req = 1'b1; bus0.cpu_we = vecs[i].we;
        bus0.cpu_addr = vecs[i].addr; bus0.cpu_wdata = vecs[i].wdata;
      end
      for (int n = 1; n <= 10 && lat == 0; n++) begin
        @(negedge clk);
        ce_seen |= bus0.mem_ce;
        we_seen |= bus0.mem_we;
        if (vecs[i].is_ldr) begin
          oth |= bus0.cpu_ready;
          if (bus0.ldr_ready) lat = n;
        end else begin
          oth |= bus0.ldr_ready;
          if (bus0.cpu_ready) lat = n;
        end
      end
      check($sformatf("v%0d latency", i),     32'(lat),            32'(vecs[i].lat));
      check($sformatf("v%0d cpu_rdata", i),   32'(bus0.cpu_rdata), 32'(vecs[i].cpu_rd));
      check($sformatf("v%0d ldr_rdata", i),   32'(bus0.ldr_rdata), 32'(vecs[i].ldr_rd));
      check($sformatf("v%0d other_ready", i), 32'(oth),            32'd0);
      check($sformatf("v%0d mem_ce_seen", i), 32'(ce_seen),        32'(vecs[i].ce_seen));
      check($sformatf("v%0d mem_we_seen", i), 32'(we_seen),        32'(vecs[i].we_seen));
      check($sformatf("v%0d LED", i),         32'(led0),           32'(vecs[i].led));
      check($sformatf("v%0d owner", i),       32'(owner0),         32'(vecs[i].is_ldr));
      bus0.cpu_req = 1'b0;
      bus0.ldr_req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d ready width", i), 32'({bus0.cpu_ready, bus0.ldr_ready}), 32'd0);
    end

    // Contention from reset: grants alternate starting with the loader.
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h3000;
    bus0.ldr_req = 1'b1; bus0.ldr_we = 1'b0; bus0.ldr_addr = 16'h0031;
    for (int k = 0; k < 4; k++) begin
      int got;
      got = -1;
      for (int n = 1; n <= 10 && got < 0; n++) begin
        @(negedge clk);
        if (bus0.ldr_ready && bus0.cpu_ready) got = 2;
        else if (bus0.ldr_ready) got = 1;
        else if (bus0.cpu_ready) got = 0;
      end
      check($sformatf("rr%0d winner", k), 32'(got), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d owner", k), 32'(owner0), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (got == 1) check($sformatf("rr%0d ldr_rdata", k), 32'(bus0.ldr_rdata), 32'h0000BEEF);
      else          check($sformatf("rr%0d cpu_rdata", k), 32'(bus0.cpu_rdata), 32'h00001234);
      if (k == 3) begin
        bus0.cpu_req = 1'b0;
        bus0.ldr_req = 1'b0;
      end
    end
    @(negedge clk);
    check("rr idle ready", 32'({bus0.cpu_ready, bus0.ldr_ready}), 32'd0);

    // Request dropped after grant still completes.
    @(negedge clk);
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h4000;
    @(negedge clk);
    bus0.cpu_req = 1'b0;
    @(negedge clk);
    check("drop early ready", 32'(bus0.cpu_ready), 32'd0);
    @(negedge clk);
    check("drop ready",     32'(bus0.cpu_ready), 32'd1);
    check("drop cpu_rdata", 32'(bus0.cpu_rdata), 32'h00005555);
    @(negedge clk);

    // IO write to make LED nonzero before the abort.
    @(negedge clk);
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'hFFFF; bus0.cpu_wdata = 16'h0155;
    @(negedge clk);
    check("io mem_ce", 32'(bus0.mem_ce), 32'd0);
    @(negedge clk);
    check("io wr ready", 32'(bus0.cpu_ready), 32'd1);
    check("io wr LED",   32'(led0),           32'h155);
    bus0.cpu_req = 1'b0;
    @(negedge clk);

    // Reset during the second ACCESS cycle of a CPU write.
    @(negedge clk);
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'hFFFE; bus0.cpu_wdata = 16'h0AAA;
    @(negedge clk);
    check("abort acc1 mem_ce", 32'(bus0.mem_ce), 32'd1);
    @(negedge clk);
    check("abort acc2 mem_we", 32'(bus0.mem_we), 32'd1);
    rst0 = 1'b1;
    bus0.cpu_req = 1'b0;
    @(negedge clk);
    check("abort cpu_ready", 32'(bus0.cpu_ready), 32'd0);
    check("abort mem_ce",    32'(bus0.mem_ce),    32'd0);
    check("abort owner",     32'(owner0),         32'd1);
    check("abort LED",       32'(led0),           32'd0);
    rst0 = 1'b0;
    @(negedge clk);
    check("abort late ready", 32'(bus0.cpu_ready), 32'd0);

    // WAIT_CYCLES=1 instance: five back-to-back CPU reads.
    @(negedge clk);
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0010;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check($sformatf("b2b%0d access ready", t), 32'(bus1.cpu_ready), 32'd0);
      @(negedge clk);
      check($sformatf("b2b%0d ready", t), 32'(bus1.cpu_ready), 32'd1);
      check($sformatf("b2b%0d rdata", t), 32'(bus1.cpu_rdata), 32'hA000 + 32'(t));
      if (t < 4) bus1.cpu_addr = 16'h0011 + 16'(t);
      else       bus1.cpu_req  = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d idle ready", t), 32'(bus1.cpu_ready), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("b2b no extra ready", 32'(bus1.cpu_ready), 32'd0);
    check("b2b ldr_ready",      32'(bus1.ldr_ready), 32'd0);
`ifdef SLC3_ARB_STATS_EN
    check("stats cpu_grants", 32'(cpu_grants1), 32'd5);
    check("stats ldr_grants", 32'(ldr_grants1), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slc3_mem_arbiter.md
Name: slc3_mem_arbiter

Overview:
Shares the single on-chip program SRAM between two requesters:
- the SLC-3 CPU's MAR/MDR memory path;
- the program loader / debug port used to fill memory before Run.

Sequences each SRAM access with a fixed wait-state count. Decodes the memory-mapped I/O address so switch reads and LED writes bypass SRAM. Sits between slc3 datapath, loader, and SRAM wrapper inside slc3_testtop.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WAIT_CYCLES, 2, SRAM access cycles after grant (legal range 1..7).
- IO_ADDR, 16'hFFFF, memory-mapped switch/LED address.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ready  (same widths/semantics as cpu_*)
- mem_ce  out  1  SRAM chip enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid on final wait cycle
- SW  in  10  board switches
- LED  out  10  LED register
- owner  out  1  0=CPU, 1=loader; current/last grant

Behaviour:
- Reset values:
  - all ready, mem_ce and mem_we = 0;
  - LED = 0, owner = 1, rdata outputs = 0;
  - state = IDLE, round-robin pointer favours loader.
- FSM states: IDLE, ACCESS, IO, DONE.
- IDLE:
  - Samples both req lines.
  - If none is asserted, stay.
  - If one is asserted, grant it.
  - If both are asserted, grant the side that was NOT granted last (round-robin); owner updates at this edge.
  - A granted non-IO address goes to ACCESS with wait counter = WAIT_CYCLES-1. IO_ADDR goes to IO.
  - Granted address, we and wdata are latched at grant; requester must still hold them stable until ready.
- ACCESS:
  - mem_ce=1; mem_addr/mem_we/mem_wdata driven from latched values.
  - Counter decrements each cycle. At counter=0, capture mem_rdata into the owner's rdata register and go to DONE.
- IO:
  - No SRAM activity (mem_ce=0).
  - Read returns {6'b0, SW}; write sets LED <= wdata[9:0].
  - Goes to DONE next cycle.
- DONE:
  - Owner's ready=1 for exactly this cycle; rdata held valid.
  - Next state is IDLE.
  - Non-owner ready stays 0 throughout.
- Latency from req sampled in IDLE to ready high:
  - SRAM: WAIT_CYCLES+1 cycles (3 at default).
  - IO: 2 cycles.
- Back-to-back: req still high in the IDLE cycle after DONE starts a new transaction. Requesters drop req in the cycle after ready when done.
- Writes: cpu_rdata/ldr_rdata unchanged (hold previous value).
- Reset mid-ACCESS or IO:
  - Transaction is aborted, no ready pulse.
  - mem_ce falls at that edge; LED is not updated by the aborted write.
- req dropping before ready: the transaction still completes and ready still pulses (no cancellation).
- Unowned port's rdata is never modified.

Optional Feature:
- Macro: SLC3_ARB_STATS_EN.
- With the macro: adds outputs cpu_grants and ldr_grants (16 bits each).
  - Each increments on the IDLE->grant edge for its requester.
  - Saturate at 16'hFFFF; reset to 0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package slc3_mem_pkg:
  - arb_state_t enum (IDLE, ACCESS, IO, DONE);
  - owner_t enum (OWN_CPU=0, OWN_LDR=1);
  - default IO_ADDR constant.
- One sub-module, slc3_mmio_regs:
  - IO_ADDR decode, SW read mux, LED register with write strobe;
  - instantiated once.
- Round-robin pick is inline.

Test Plan:
- CPU read alone: SRAM[0x3000]=0x1234, cpu_req=1 addr 0x3000 -> cpu_ready pulses 3 cycles after sample, cpu_rdata=0x1234, ldr_ready stays 0.
- Loader write then CPU read: ldr writes 0xBEEF to 0x0031, then CPU reads 0x0031 -> mem_we=1 only during loader ACCESS; CPU gets 0xBEEF.
- Simultaneous requests from reset, both held for 4 transactions -> grant order LDR, CPU, LDR, CPU; owner toggles each grant.
- IO path: SW=10'h05A, CPU read 0xFFFF -> cpu_rdata=0x005A in 2 cycles, mem_ce never high. CPU write 0x03C7 to 0xFFFF -> LED=10'h3C7.
- Reset asserted on 2nd ACCESS cycle of CPU write to 0xFFFE -> no cpu_ready; next cycle mem_ce=0; owner=1; LED=0.
- WAIT_CYCLES=1 build with SLC3_ARB_STATS_EN: 5 CPU reads back-to-back -> each ready 2 cycles after sample; cpu_grants=5, ldr_grants=0.
